// File: rtl/seq_det_pkg.sv
// Shared types for the parametrised serial sequence detector.
package seq_det_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } seq_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sat flags the all-ones value.
module sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && !(&count_q)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign sat   = &count_q;

endmodule

// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector: Moore FSM comparing the last PAT_LEN enabled bits
// against a loadable pattern, with overlap/single-shot modes and a match counter.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int unsigned PAT_LEN = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               w,
    input  logic               arm,
    input  logic               single_shot,
    input  logic               overlap,
    input  logic               load_pat,
    input  logic [PAT_LEN-1:0] pat_in,
    output logic               z,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   match_count,
    output logic               count_sat
);

    localparam int unsigned FILL_W = $clog2(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);

    seq_state_t         state_q, state_d;
    logic [PAT_LEN-1:0] pat_q, pat_d;
    logic [PAT_LEN-2:0] hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               z_q;

    logic [PAT_LEN-1:0] win;
    logic               sample;
    logic               hit;
    logic               clr;

    // load_pat and arm both outrank the data bit, so a bit on those edges is dropped.
    always_comb begin
        win    = {hist_q, w};
        sample = (state_q == ST_SEARCH) && en && !load_pat && !arm;
        hit    = sample && (fill_q == FILL_MAX) && (win == pat_q);
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        clr     = 1'b0;
        if (load_pat) begin
            pat_d  = pat_in;
            hist_d = '0;
            fill_d = '0;
        end else if (arm) begin
            state_d = ST_SEARCH;
            hist_d  = '0;
            fill_d  = '0;
            clr     = 1'b1;
        end else if (sample) begin
            hist_d = win[PAT_LEN-2:0];
            if (hit && !overlap) begin
                fill_d = '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + 1'b1;
            end
            if (hit && single_shot) begin
                state_d = ST_DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            hist_q  <= '0;
            fill_q  <= '0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            z_q     <= hit;
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_sat_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .inc  (hit),
        .count(match_count),
        .sat  (count_sat)
    );

    assign z    = z_q;
    assign busy = (state_q == ST_SEARCH);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench: expected z per driven bit is queued, popped after the sampling edge.
module tb_seq_detector_param;

    localparam int unsigned PAT_LEN = 4;
    localparam int unsigned CNT_W   = 2;

    logic               clk = 1'b0;
    logic               rst, en, w, arm, single_shot, overlap, load_pat;
    logic [PAT_LEN-1:0] pat_in;
    logic               z, busy, done, count_sat;
    logic [CNT_W-1:0]   match_count;

    int   n_asrt = 0;
    int   n_fail = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    seq_detector_param #(
        .PAT_LEN(PAT_LEN),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .w          (w),
        .arm        (arm),
        .single_shot(single_shot),
        .overlap    (overlap),
        .load_pat   (load_pat),
        .pat_in     (pat_in),
        .z          (z),
        .busy       (busy),
        .done       (done),
        .match_count(match_count),
        .count_sat  (count_sat)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_asrt++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: drive at negedge, DUT samples at posedge, check z at next negedge.
    task automatic cycle(input string tag, input logic expz);
        logic e;
        exp_q.push_back(expz);
        @(posedge clk);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            n_asrt++;
            n_fail++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            chk(tag, {31'd0, z}, {31'd0, e});
        end
    endtask

    task automatic step(input logic e, input logic b, input logic expz);
        en = e;
        w  = b;
        cycle("z", expz);
        en = 1'b0;
    endtask

    task automatic do_load(input logic [PAT_LEN-1:0] p);
        load_pat = 1'b1;
        pat_in   = p;
        cycle("z_load", 1'b0);
        load_pat = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        cycle("z_arm", 1'b0);
        arm = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; w = 1'b0; arm = 1'b0; single_shot = 1'b0;
        overlap = 1'b0; load_pat = 1'b0; pat_in = '0;
        @(negedge clk);
        cycle("z_rst", 1'b0);
        rst = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_count", {30'd0, match_count}, 32'd0);
        chk("rst_sat", {31'd0, count_sat}, 32'd0);

        // Overlapping matches
        do_load(4'b1011);
        chk("idle_after_load", {31'd0, busy}, 32'd0);
        overlap = 1'b1;
        do_arm();
        chk("busy_arm", {31'd0, busy}, 32'd1);
        step(1, 1, 0); step(1, 0, 0); step(1, 1, 0); step(1, 1, 1);
        step(1, 0, 0); step(1, 1, 0); step(1, 1, 1);
        chk("ovl_count", {30'd0, match_count}, 32'd2);

        // Non-overlapping: trailing 011 cannot reuse the matched bits
        overlap = 1'b0;
        do_arm();
        chk("arm_clr_count", {30'd0, match_count}, 32'd0);
        step(1, 1, 0); step(1, 0, 0); step(1, 1, 0); step(1, 1, 1);
        step(1, 0, 0); step(1, 1, 0); step(1, 1, 0);
        step(1, 1, 0); step(1, 0, 0); step(1, 1, 0); step(1, 1, 1);
        chk("novl_count", {30'd0, match_count}, 32'd2);

        // Single-shot
        overlap = 1'b1;
        single_shot = 1'b1;
        do_arm();
        step(1, 1, 0); step(1, 0, 0); step(1, 1, 0); step(1, 1, 1);
        chk("ss_done", {31'd0, done}, 32'd1);
        chk("ss_busy", {31'd0, busy}, 32'd0);
        step(1, 1, 0); step(1, 0, 0); step(1, 1, 0); step(1, 1, 0);
        chk("ss_count", {30'd0, match_count}, 32'd1);
        do_arm();
        chk("rearm_busy", {31'd0, busy}, 32'd1);
        chk("rearm_done", {31'd0, done}, 32'd0);
        step(1, 1, 0); step(1, 0, 0); step(1, 1, 0); step(1, 1, 1);
        chk("rearm_done2", {31'd0, done}, 32'd1);
        single_shot = 1'b0;

        // Enable gaps
        do_arm();
        step(1, 1, 0); step(1, 0, 0);
        step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
        step(1, 1, 0); step(1, 1, 1);
        step(0, 1, 0);
        chk("gap_count", {30'd0, match_count}, 32'd1);

        // Saturation on a 2-bit counter
        do_arm();
        step(1, 1, 0); step(1, 0, 0); step(1, 1, 0); step(1, 1, 1);
        step(1, 0, 0); step(1, 1, 0); step(1, 1, 1);
        chk("sat_cnt2", {30'd0, match_count}, 32'd2);
        chk("sat_flag2", {31'd0, count_sat}, 32'd0);
        step(1, 0, 0); step(1, 1, 0); step(1, 1, 1);
        chk("sat_cnt3", {30'd0, match_count}, 32'd3);
        chk("sat_flag3", {31'd0, count_sat}, 32'd1);
        step(1, 0, 0); step(1, 1, 0); step(1, 1, 1);
        chk("sat_cnt4", {30'd0, match_count}, 32'd3);
        chk("sat_flag4", {31'd0, count_sat}, 32'd1);

        // Synchronous reset mid-search
        do_arm();
        step(1, 1, 0); step(1, 0, 0); step(1, 1, 0);
        rst = 1'b1;
        cycle("z_midrst", 1'b0);
        rst = 1'b0;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_count", {30'd0, match_count}, 32'd0);
        chk("midrst_sat", {31'd0, count_sat}, 32'd0);
        step(1, 1, 0);
        do_load(4'b1011);
        do_arm();
        step(1, 1, 0); step(1, 0, 0); step(1, 1, 0); step(1, 1, 1);

        // Load with a coincident bit: bit dropped, history cleared, state kept
        load_pat = 1'b1; pat_in = 4'b0110; en = 1'b1; w = 1'b1;
        cycle("z_load_bit", 1'b0);
        load_pat = 1'b0; en = 1'b0;
        chk("load_busy", {31'd0, busy}, 32'd1);
        step(1, 0, 0); step(1, 1, 0); step(1, 1, 0); step(1, 0, 1);
        step(1, 0, 0); step(1, 1, 0); step(1, 1, 0);
        load_pat = 1'b1; pat_in = 4'b0110; en = 1'b1; w = 1'b0;
        cycle("z_load_clr", 1'b0);
        load_pat = 1'b0;
        step(1, 0, 0);
        step(1, 1, 0); step(1, 1, 0); step(1, 0, 1);

        if (exp_q.size() != 0) begin
            n_asrt++;
            n_fail++;
            $error("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
